// File: rtl/clk_ratio_monitor_if.sv
// ============================================================================
// clk_ratio_monitor_if
// ----------------------------------------------------------------------------
// Bundles the run-control inputs and the status outputs of clk_ratio_monitor.
// Clock and reset stay plain ports on the monitor itself.
//
// Signals:
//   enable          run control (master -> monitor)
//   ppu_toggle      level that inverts on every clk_ppu rising edge
//                   (asynchronous to the monitor clock)
//   err_clear       clears the sticky fault flag
//   measured        transition count of the last evaluated window
//   measured_valid  one-cycle pulse when measured updates
//   freq_ok         lock indicator
//   err_sticky      set when a locked state is lost
//
// Modports:
//   master  drives the controls, observes the status (status/debug side)
//   slave   the monitor itself
// ============================================================================
interface clk_ratio_monitor_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic             ppu_toggle;
    logic             err_clear;
    logic [CNT_W-1:0] measured;
    logic             measured_valid;
    logic             freq_ok;
    logic             err_sticky;

    modport master (
        output enable,
        output ppu_toggle,
        output err_clear,
        input  measured,
        input  measured_valid,
        input  freq_ok,
        input  err_sticky
    );

    modport slave (
        input  enable,
        input  ppu_toggle,
        input  err_clear,
        output measured,
        output measured_valid,
        output freq_ok,
        output err_sticky
    );
endinterface

// File: rtl/clk_ratio_monitor.sv
// ============================================================================
// clk_ratio_monitor
// ----------------------------------------------------------------------------
// Checks the PPU clock against the HDMI pixel clock. A toggle level from the
// clk_ppu domain is synchronised into clk_hdmi, its transitions are counted
// over a fixed window of clk_hdmi cycles, and each window count is compared
// against the nominal count. Enough consecutive good windows declare lock;
// a bad window while locked drops lock and raises a sticky fault.
//
// Ports:
//   clk_hdmi    in   the only clock
//   rst_hdmi_n  in   asynchronous active-low reset
//   mon         slave modport of clk_ratio_monitor_if
//                 (enable, ppu_toggle, err_clear in;
//                  measured, measured_valid, freq_ok, err_sticky out)
//
// Parameters:
//   WINDOW_CYCLES   clk_hdmi cycles per measurement window
//   EXPECTED_COUNT  nominal toggle transitions per window
//   TOLERANCE       allowed absolute deviation from EXPECTED_COUNT
//   GOOD_WINDOWS    consecutive good windows needed to declare lock
//   CNT_W           width of the edge and window counters
// ============================================================================
module clk_ratio_monitor #(
    parameter int WINDOW_CYCLES  = 1716,
    parameter int EXPECTED_COUNT = 341,
    parameter int TOLERANCE      = 2,
    parameter int GOOD_WINDOWS   = 4,
    parameter int CNT_W          = 12
) (
    input  logic                 clk_hdmi,
    input  logic                 rst_hdmi_n,
    clk_ratio_monitor_if.slave   mon
);

    localparam int CW1    = CNT_W + 1;
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W:0]    EXP_V     = CW1'(EXPECTED_COUNT);
    localparam logic [CNT_W:0]    TOL_V     = CW1'(TOLERANCE);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_ACQUIRE = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    // ------------------------------------------------------------------------
    // Synchroniser: bit 0 = s1, bit 1 = s2, bit 2 = s3 (history).
    // ------------------------------------------------------------------------
    logic [2:0] sync_reg;

    always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
        if (!rst_hdmi_n) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], mon.ppu_toggle};
        end
    end

    logic edge_det;
    assign edge_det = sync_reg[1] ^ sync_reg[2];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state_reg,      state_next;
    logic [CNT_W-1:0]  edge_cnt_reg,   edge_cnt_next;
    logic [CNT_W-1:0]  win_cnt_reg,    win_cnt_next;
    logic [GOOD_W-1:0] good_cnt_reg,   good_cnt_next;
    logic [CNT_W-1:0]  measured_reg,   measured_next;
    logic              valid_reg,      valid_next;
    logic              freq_ok_reg,    freq_ok_next;
    logic              err_sticky_reg, err_sticky_next;
    logic              err_set;

    // ------------------------------------------------------------------------
    // Window arithmetic
    // ------------------------------------------------------------------------
    logic             win_end;
    logic [CNT_W-1:0] edge_cnt_inc;
    logic [CNT_W:0]   meas_ext;
    logic [CNT_W:0]   deviation;
    logic             window_good;

    assign win_end = (win_cnt_reg == WIN_LAST);

    // Saturating edge_cnt + edge. At the window end this is also the window
    // total, so an edge seen in the terminal cycle belongs to the closing
    // window.
    assign edge_cnt_inc = (edge_det && (edge_cnt_reg != {CNT_W{1'b1}}))
                        ? edge_cnt_reg + 1'b1
                        : edge_cnt_reg;

    // One extra bit and an ordered subtraction keep the absolute deviation
    // free of wrap-around.
    assign meas_ext    = {1'b0, edge_cnt_inc};
    assign deviation   = (meas_ext >= EXP_V) ? (meas_ext - EXP_V) : (EXP_V - meas_ext);
    assign window_good = (deviation <= TOL_V);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        good_cnt_next = good_cnt_reg;
        measured_next = measured_reg;
        valid_next    = 1'b0;
        freq_ok_next  = freq_ok_reg;
        err_set       = 1'b0;

        // Counting runs in every active state, DISCARD included.
        if (state_reg != ST_IDLE) begin
            if (win_end) begin
                edge_cnt_next = '0;
                win_cnt_next  = '0;
            end else begin
                edge_cnt_next = edge_cnt_inc;
                win_cnt_next  = win_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                edge_cnt_next = '0;
                win_cnt_next  = '0;
                good_cnt_next = '0;
                freq_ok_next  = 1'b0;
                if (mon.enable) begin
                    state_next = ST_DISCARD;
                end
            end

            // First window only flushes stale synchroniser history and
            // startup transients; its result is thrown away.
            ST_DISCARD: begin
                if (win_end) begin
                    state_next    = ST_ACQUIRE;
                    good_cnt_next = '0;
                end
            end

            ST_ACQUIRE: begin
                if (win_end) begin
                    measured_next = edge_cnt_inc;
                    valid_next    = 1'b1;
                    if (window_good) begin
                        if (good_cnt_reg == GOOD_LAST) begin
                            state_next    = ST_LOCKED;
                            freq_ok_next  = 1'b1;
                            good_cnt_next = '0;
                        end else begin
                            good_cnt_next = good_cnt_reg + 1'b1;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
            end

            ST_LOCKED: begin
                if (win_end) begin
                    measured_next = edge_cnt_inc;
                    valid_next    = 1'b1;
                    if (!window_good) begin
                        state_next    = ST_ACQUIRE;
                        freq_ok_next  = 1'b0;
                        good_cnt_next = '0;
                        err_set       = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Dropping enable abandons any window in progress; measured and
        // err_sticky keep their last values.
        if (!mon.enable) begin
            state_next    = ST_IDLE;
            edge_cnt_next = '0;
            win_cnt_next  = '0;
            good_cnt_next = '0;
            measured_next = measured_reg;
            valid_next    = 1'b0;
            freq_ok_next  = 1'b0;
            err_set       = 1'b0;
        end

        // A set in the same cycle as err_clear wins.
        err_sticky_next = err_set | (err_sticky_reg & ~mon.err_clear);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
        if (!rst_hdmi_n) begin
            state_reg      <= ST_IDLE;
            edge_cnt_reg   <= '0;
            win_cnt_reg    <= '0;
            good_cnt_reg   <= '0;
            measured_reg   <= '0;
            valid_reg      <= 1'b0;
            freq_ok_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            edge_cnt_reg   <= edge_cnt_next;
            win_cnt_reg    <= win_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            measured_reg   <= measured_next;
            valid_reg      <= valid_next;
            freq_ok_reg    <= freq_ok_next;
            err_sticky_reg <= err_sticky_next;
        end
    end

    assign mon.measured       = measured_reg;
    assign mon.measured_valid = valid_reg;
    assign mon.freq_ok        = freq_ok_reg;
    assign mon.err_sticky     = err_sticky_reg;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// ============================================================================
// tb_clk_ratio_monitor
// ----------------------------------------------------------------------------
// Directed bench for clk_ratio_monitor with default parameters.
// ppu_toggle comes from a phase accumulator advanced once per clk_hdmi cycle:
// with increment R modulo 1716, every run of 1716 consecutive cycles holds
// exactly R transitions, so any aligned window measures exactly R.
// Cycle numbering: edge 0 is the first edge that sees enable = 1, and
// "cycle k" is observed at the falling edge after edge k-1.
// ============================================================================
module tb_clk_ratio_monitor;

    localparam int W = 1716;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_ratio_monitor_if #(.CNT_W(12)) bus ();

    clk_ratio_monitor #(
        .WINDOW_CYCLES (1716),
        .EXPECTED_COUNT(341),
        .TOLERANCE     (2),
        .GOOD_WINDOWS  (4),
        .CNT_W         (12)
    ) dut (
        .clk_hdmi  (clk),
        .rst_hdmi_n(rst_n),
        .mon       (bus)
    );

    typedef struct {
        int rate;         // transitions per 1716 cycles
        int run_to;       // last cycle observed
        int exp_meas;     // measured after the last window
        int exp_nvalid;   // measured_valid pulses seen
        int exp_fo_rise;  // cycle freq_ok first reads 1, -1 = never
        int exp_fo;       // freq_ok at run_to
    } vec_t;

    vec_t vecs [4];

    int   nchk = 0;
    int   nerr = 0;
    int   cyc;
    int   first_valid, first_meas, last_meas, nvalid, fo_rise;
    logic fo_prev;
    int   rate;
    int   acc;
    int   freeze_at;
    logic tog;
    int   nv_save;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_track();
        first_valid = -1;
        first_meas  = -1;
        last_meas   = -1;
        nvalid      = 0;
        fo_rise     = -1;
        fo_prev     = bus.freq_ok;
    endtask

    // Advance one cycle: observe outputs, then move the toggle generator.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.measured_valid) begin
            nvalid++;
            last_meas = int'(bus.measured);
            if (first_valid < 0) begin
                first_valid = cyc;
                first_meas  = int'(bus.measured);
            end
        end
        if (bus.freq_ok && !fo_prev && fo_rise < 0) fo_rise = cyc;
        fo_prev = bus.freq_ok;
        if (!(freeze_at >= 0 && cyc >= freeze_at)) begin
            acc = acc + rate;
            if (acc >= W) begin
                acc = acc - W;
                tog = ~tog;
                bus.ppu_toggle = tog;
            end
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        bus.enable    = 1'b0;
        bus.err_clear = 1'b0;
        rst_n         = 1'b0;
        freeze_at     = -1;
        acc           = 0;
        repeat (3) @(negedge clk);
        check("rst_measured",   int'(bus.measured),       0);
        check("rst_valid",      int'(bus.measured_valid), 0);
        check("rst_freq_ok",    int'(bus.freq_ok),        0);
        check("rst_err_sticky", int'(bus.err_sticky),     0);
        rst_n = 1'b1;
    endtask

    task automatic start(input int r);
        rate       = r;
        bus.enable = 1'b1;
        cyc        = 0;
        clear_track();
    endtask

    initial begin
        tog            = 1'b0;
        bus.ppu_toggle = 1'b0;
        bus.enable     = 1'b0;
        bus.err_clear  = 1'b0;
        cyc            = 0;
        rate           = 0;
        acc            = 0;
        freeze_at      = -1;
        clear_track();

        vecs[0] = '{rate: 344, run_to: 8581, exp_meas: 344, exp_nvalid: 4, exp_fo_rise: -1,   exp_fo: 0};
        vecs[1] = '{rate: 339, run_to: 8581, exp_meas: 339, exp_nvalid: 4, exp_fo_rise: 8581, exp_fo: 1};
        vecs[2] = '{rate: 343, run_to: 8581, exp_meas: 343, exp_nvalid: 4, exp_fo_rise: 8581, exp_fo: 1};
        vecs[3] = '{rate: 338, run_to: 8581, exp_meas: 338, exp_nvalid: 4, exp_fo_rise: -1,   exp_fo: 0};

        // ---------------- table-driven rate sweep ----------------
        for (int i = 0; i < 4; i++) begin
            do_reset();
            start(vecs[i].rate);
            run_until(vecs[i].run_to);
            check("vec_first_valid", first_valid, 3433);
            check("vec_measured",    last_meas,   vecs[i].exp_meas);
            check("vec_nvalid",      nvalid,      vecs[i].exp_nvalid);
            check("vec_fo_rise",     fo_rise,     vecs[i].exp_fo_rise);
            check("vec_freq_ok",     int'(bus.freq_ok),    vecs[i].exp_fo);
            check("vec_err_sticky",  int'(bus.err_sticky), 0);
            $display("vec %0d: rate=%0d measured=%0d pulses=%0d freq_ok_rise=%0d freq_ok=%0d",
                     i, vecs[i].rate, last_meas, nvalid, fo_rise, bus.freq_ok);
        end

        // ---------------- nominal lock ----------------
        do_reset();
        start(341);
        run_until(8581);
        check("nom_first_valid", first_valid, 3433);
        check("nom_first_meas",  first_meas,  341);
        check("nom_fo_rise",     fo_rise,     8581);
        check("nom_err_sticky",  int'(bus.err_sticky), 0);
        $display("nominal: first_valid=%0d measured=%0d freq_ok_rise=%0d", first_valid, last_meas, fo_rise);

        // ---------------- enable drop while locked ----------------
        run_until(9000);
        bus.enable = 1'b0;
        nv_save = nvalid;
        step();
        check("drop_freq_ok",  int'(bus.freq_ok),        0);
        check("drop_valid",    int'(bus.measured_valid), 0);
        check("drop_measured", int'(bus.measured),       341);
        run_until(9010);
        check("drop_no_pulse", nvalid, nv_save);
        $display("enable drop: freq_ok=%0d measured=%0d", bus.freq_ok, bus.measured);

        // Re-enable: a DISCARD window must run again before the first pulse.
        // Toggles stop from cycle 8577 so the window after lock reads 0.
        start(341);
        freeze_at = 8577;
        run_until(8581);
        check("reen_first_valid", first_valid, 3433);
        check("reen_first_meas",  first_meas,  341);
        check("reen_fo_rise",     fo_rise,     8581);
        $display("re-enable: first_valid=%0d freq_ok_rise=%0d", first_valid, fo_rise);

        // ---------------- loss of clock + clear race ----------------
        run_until(10296);
        check("loss_pre_fo",  int'(bus.freq_ok),    1);
        check("loss_pre_err", int'(bus.err_sticky), 0);
        bus.err_clear = 1'b1;              // same cycle as the failing window end
        step();
        bus.err_clear = 1'b0;
        check("loss_valid",    int'(bus.measured_valid), 1);
        check("loss_measured", int'(bus.measured),       0);
        check("loss_freq_ok",  int'(bus.freq_ok),        0);
        check("race_err_set",  int'(bus.err_sticky),     1);
        $display("loss: measured=%0d freq_ok=%0d err_sticky=%0d", bus.measured, bus.freq_ok, bus.err_sticky);
        freeze_at = -1;
        clear_track();
        run_until(17161);
        check("relock_fo_rise", fo_rise, 17161);
        check("relock_meas",    last_meas, 341);
        check("relock_err",     int'(bus.err_sticky), 1);
        $display("relock: freq_ok_rise=%0d err_sticky=%0d", fo_rise, bus.err_sticky);

        // ---------------- asynchronous reset mid-window ----------------
        run_until(17500);
        check("pre_arst_meas", int'(bus.measured),   341);
        check("pre_arst_fo",   int'(bus.freq_ok),    1);
        check("pre_arst_err",  int'(bus.err_sticky), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_measured", int'(bus.measured),       0);
        check("arst_valid",    int'(bus.measured_valid), 0);
        check("arst_freq_ok",  int'(bus.freq_ok),        0);
        check("arst_err",      int'(bus.err_sticky),     0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        clear_track();
        freeze_at = 8577;
        run_until(8581);
        check("post_arst_first_valid", first_valid, 3433);
        check("post_arst_fo_rise",     fo_rise,     8581);
        $display("async reset: first_valid=%0d freq_ok_rise=%0d", first_valid, fo_rise);

        // ---------------- clear one cycle after the failing window ----------------
        run_until(10297);
        check("late_err_set",  int'(bus.err_sticky), 1);
        check("late_measured", int'(bus.measured),   0);
        check("late_freq_ok",  int'(bus.freq_ok),    0);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        check("late_err_cleared", int'(bus.err_sticky), 0);
        $display("late clear: err_sticky=%0d", bus.err_sticky);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
